// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Shares one AND/OR/XOR/ADD datapath of width `size` between
//               two requesters. Round-robin arbitration, operand capture,
//               one registered execute cycle, then the result is held with
//               res_valid until the consumer acknowledges it.
// Ports       : clk, rst           - clock, async active-high reset
//               req*/op*/a*/b*     - requester 0/1 request, opcode, operands
//               gnt0/gnt1          - one-cycle capture pulses
//               c/carry            - result and ADD carry-out
//               res_valid/res_id   - result valid (held) and owning requester
//               res_ack            - consumer accepts result
//               busy               - arbiter not idle
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int size = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic [1:0]      op0,
    input  logic [size-1:0] a0,
    input  logic [size-1:0] b0,
    input  logic            req1,
    input  logic [1:0]      op1,
    input  logic [size-1:0] a1,
    input  logic [size-1:0] b1,
    output logic            gnt0,
    output logic            gnt1,
    output logic [size-1:0] c,
    output logic            carry,
    output logic            res_valid,
    output logic            res_id,
    input  logic            res_ack,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] c_OP_AND = 2'b00;
    localparam logic [1:0] c_OP_OR  = 2'b01;
    localparam logic [1:0] c_OP_XOR = 2'b10;

    state_t          r_state;
    logic            r_ptr;
    logic            r_win;
    logic [1:0]      r_op;
    logic [size-1:0] r_a;
    logic [size-1:0] r_b;
    logic            r_gnt0;
    logic            r_gnt1;
    logic [size-1:0] r_c;
    logic            r_carry;
    logic            r_res_valid;
    logic            r_res_id;
    logic            r_busy;

    // Requester 1 wins when it is alone, or when both ask and the pointer
    // favours it; otherwise requester 0 wins.
    logic            w_pick1;
    logic [size:0]   w_sum;
    logic [size-1:0] w_res;
    logic            w_carry;

    assign w_pick1 = req1 & (~req0 | r_ptr);
    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        case (r_op)
            c_OP_AND: w_res = r_a & r_b;
            c_OP_OR:  w_res = r_a | r_b;
            c_OP_XOR: w_res = r_a ^ r_b;
            default: begin
                w_res   = w_sum[size-1:0];
                w_carry = w_sum[size];
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 1'b0;
            r_win       <= 1'b0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_c         <= '0;
            r_carry     <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_id    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Grants are single-cycle pulses: cleared unless re-set below.
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_win   <= w_pick1;
                        r_op    <= w_pick1 ? op1 : op0;
                        r_a     <= w_pick1 ? a1  : a0;
                        r_b     <= w_pick1 ? b1  : b0;
                        r_gnt0  <= ~w_pick1;
                        r_gnt1  <= w_pick1;
                        r_state <= S_EXEC;
                        r_busy  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_c         <= w_res;
                    r_carry     <= w_carry;
                    r_res_valid <= 1'b1;
                    r_res_id    <= r_win;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (res_ack) begin
                        r_res_valid <= 1'b0;
                        r_ptr       <= ~r_res_id;
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign c         = r_c;
    assign carry     = r_carry;
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one parameterized bitwise/arithmetic ALU datapath (AND/OR/XOR/ADD, width `size`) between two requesters.
- Round-robin arbitration, operand capture, registered execution, result hand-back with valid/ack handshake.
- Sits between the lab-level operand sources and the ALU slice; one operation in flight at a time.

Parameters:
- size, 4, operand and result width in bits (>=1)

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- req0  input  1  requester 0 operation request (level)
- op0  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 ADD
- a0  input  size  requester 0 operand a
- b0  input  size  requester 0 operand b
- req1  input  1  requester 1 operation request (level)
- op1  input  2  requester 1 opcode
- a1  input  size  requester 1 operand a
- b1  input  size  requester 1 operand b
- gnt0  output  1  one-cycle pulse: requester 0 operands captured
- gnt1  output  1  one-cycle pulse: requester 1 operands captured
- c  output  size  result
- carry  output  1  ADD carry-out; 0 for logic ops
- res_valid  output  1  result valid, held until acknowledged
- res_id  output  1  requester that owns c (0 or 1)
- res_ack  input  1  consumer accepts result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high. All outputs and state are registered.
- Reset values:
  - gnt0=gnt1=0, c=0, carry=0, res_valid=0, res_id=0, busy=0.
  - state=IDLE, priority pointer=0 (requester 0 favoured).
  - Captured operand/opcode registers=0.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - At a clock edge with any req high, pick the winner. If both are high, take the pointer's requester; otherwise take the single requester.
  - Capture that requester's op/a/b, pulse its gnt for exactly one cycle (the cycle after the edge), go to EXEC.
  - With no req, stay in IDLE.
- EXEC (one cycle):
  - Compute from the captured registers and register the results into c/carry.
  - ADD: {carry,c} = a+b in size+1 bits, i.e. c = sum mod 2^size.
  - Logic ops: carry=0.
  - Set res_valid=1 and res_id=winner, go to DONE.
- DONE:
  - Hold c/carry/res_id/res_valid stable until res_ack is sampled high.
  - On ack: clear res_valid, set pointer = ~res_id, go to IDLE.
  - c/carry keep their last value after ack.
- Latency: request edge -> gnt 1 cycle -> res_valid 2 cycles after the request edge. Minimum 3 cycles per operation (including the ack cycle).
- Requests:
  - Requester inputs are sampled only in IDLE; changes in EXEC/DONE are ignored.
  - A req still high after its gnt is treated as a new request.
  - The loser keeps req asserted and is served next.
- res_ack outside DONE is ignored. res_ack held continuously acks each result in its first DONE cycle.
- Simultaneous req0/req1: exactly one gnt pulses; gnt0 and gnt1 are never high together.
- Reset mid-operation: return immediately to reset values. The captured operation is discarded and no result is produced.

Test Plan:
- Reset, single request: assert rst, then release it; req0=1, op0=00, a0=4'hC, b0=4'hA. Required: gnt0 pulses 1 cycle, res_valid=1 two cycles after the sampling edge, c=4'h8, carry=0, res_id=0. res_ack=1 -> res_valid=0, busy=0.
- ADD overflow: req1=1, op1=11, a1=4'hF, b1=4'h3 -> c=4'h2, carry=1, res_id=1.
- Contention and fairness: req0 and req1 held high from reset; op0=01 (a0=4'h5, b0=4'hA), op1=10 (a1=4'hF, b1=4'h3); ack each result.
  - First result: c=4'hF, res_id=0. Second result: c=4'hC, res_id=1.
  - Grants alternate 0,1,0,1; gnt0 and gnt1 are never both high.
- Result hold: leave res_ack=0 for 10 cycles and change a0/b0/op0 meanwhile. Required: c, res_id and res_valid remain unchanged, and no new gnt is issued.
- Reset mid-operation: assert rst during EXEC (after gnt0). Required: all outputs return to reset values asynchronously with no res_valid pulse, and after release the pointer favours requester 0.
- Exhaustive sweep: an `always #2` increment of {op,a,b} over all 2^10 combinations on requester 0 with auto-ack. Required: every result matches the AND/OR/XOR/ADD model, and carry=0 for logic ops.
